// File: rtl/cg_sram_responder_if.sv
// CG memory handshake bundle: read-address, read-data and write-beat channels.
// master: requester side; slave: memory responder side.
//   raddr_valid/raddr_ready/raddr  - read address channel
//   rdata_valid/rdata_ready/rdata  - read response channel (in request order)
//   wdata_valid/wdata_ready/wen/waddr/wdata - write beat channel
interface cg_sram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  raddr_valid;
    logic                  raddr_ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rdata_valid;
    logic                  rdata_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output raddr_valid, raddr, rdata_ready, wdata_valid, wen, waddr, wdata,
        input  raddr_ready, rdata_valid, rdata, wdata_ready
    );

    modport slave (
        input  raddr_valid, raddr, rdata_ready, wdata_valid, wen, waddr, wdata,
        output raddr_ready, rdata_valid, rdata, wdata_ready
    );
endinterface

// File: rtl/cg_sram_responder.sv
// Memory-side responder for the CG memory handshake. Owns a single-port word
// array, arbitrates one read or write per cycle with bounded read starvation,
// and returns read data in order through a credit-limited response queue.
// Ports:
//   i_clk  - clock, all state on rising edge
//   i_rst  - asynchronous active-high reset
//   bus    - cg_sram_responder_if.slave (read address, read data, write beats)
// Optional (macro CG_SRAM_RESPONDER_STATS_EN):
//   o_rd_count, o_wr_count, o_stall_count - saturating 32-bit activity counters
module cg_sram_responder #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    cg_sram_responder_if.slave bus
`ifdef CG_SRAM_RESPONDER_STATS_EN
    ,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count,
    output logic [31:0] o_stall_count
`endif
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned A_USE  = (IDX_W < ADDR_WIDTH) ? IDX_W : ADDR_WIDTH;
    localparam int unsigned OCNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned QPTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned SCNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned NSTG   = READ_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_mem [RESP_DEPTH];
    logic [QPTR_W-1:0]     q_wptr, q_rptr;
    logic [OCNT_W-1:0]     q_cnt;
    logic [OCNT_W-1:0]     out_cnt;
    logic [SCNT_W-1:0]     starve_cnt;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  credit_c, rd_grant_c, wr_grant_c, rsp_take_c, q_pop_c;
    logic                  q_push_c;
    logic [DATA_WIDTH-1:0] q_push_data_c;
    logic [IDX_W-1:0]      ridx_c, widx_c;

    assign ridx_c = IDX_W'(bus.raddr[A_USE-1:0]);
    assign widx_c = IDX_W'(bus.waddr[A_USE-1:0]);

    function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
        return (p == QPTR_W'(RESP_DEPTH - 1)) ? '0 : p + QPTR_W'(1);
    endfunction

    // Arbitration: writes win unless a read with credit has waited STARVE_LIMIT grants
    always_comb begin
        credit_c   = out_cnt < OCNT_W'(RESP_DEPTH);
        rd_grant_c = 1'b0;
        wr_grant_c = 1'b0;
        if (!i_rst) begin
            if (bus.raddr_valid && credit_c &&
                (!bus.wdata_valid || starve_cnt == SCNT_W'(STARVE_LIMIT))) begin
                rd_grant_c = 1'b1;
            end else if (bus.wdata_valid) begin
                wr_grant_c = 1'b1;
            end
        end
    end

    assign bus.raddr_ready = rd_grant_c;
    assign bus.wdata_ready = wr_grant_c;
    assign bus.rdata_valid = rsp_valid;
    assign bus.rdata       = rsp_data;

    assign rsp_take_c = rsp_valid && bus.rdata_ready;
    assign q_pop_c    = (q_cnt != '0) && (!rsp_valid || bus.rdata_ready);

    // Starvation counter: counts writes that beat a creditable waiting read
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (rd_grant_c || !bus.raddr_valid) begin
            starve_cnt <= '0;
        end else if (wr_grant_c && credit_c && starve_cnt != SCNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SCNT_W'(1);
        end
    end

    // Outstanding reads: pipeline + queue + presented response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_cnt <= '0;
        end else begin
            case ({rd_grant_c, rsp_take_c})
                2'b10:   out_cnt <= out_cnt + OCNT_W'(1);
                2'b01:   out_cnt <= out_cnt - OCNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Word array; contents survive reset
    always_ff @(posedge i_clk) begin
        if (wr_grant_c && bus.wen) begin
            mem[widx_c] <= bus.wdata;
        end
    end

    // Read pipeline: array sampled at the accept edge, READ_LATENCY-1 stages to queue
    generate
        if (NSTG == 0) begin : g_no_pipe
            assign q_push_c      = rd_grant_c;
            assign q_push_data_c = mem[ridx_c];
        end else begin : g_pipe
            logic [NSTG-1:0]       pv;
            logic [DATA_WIDTH-1:0] pd [NSTG];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    pv <= '0;
                    for (int i = 0; i < int'(NSTG); i++) pd[i] <= '0;
                end else begin
                    pv[0] <= rd_grant_c;
                    pd[0] <= mem[ridx_c];
                    for (int i = 1; i < int'(NSTG); i++) begin
                        pv[i] <= pv[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end
            assign q_push_c      = pv[NSTG-1];
            assign q_push_data_c = pd[NSTG-1];
        end
    endgenerate

    // Response queue storage
    always_ff @(posedge i_clk) begin
        if (q_push_c) begin
            q_mem[q_wptr] <= q_push_data_c;
        end
    end

    // Response queue pointers; credit keeps it from overflowing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_wptr <= '0;
            q_rptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (q_push_c) q_wptr <= ptr_inc(q_wptr);
            if (q_pop_c)  q_rptr <= ptr_inc(q_rptr);
            case ({q_push_c, q_pop_c})
                2'b10:   q_cnt <= q_cnt + OCNT_W'(1);
                2'b01:   q_cnt <= q_cnt - OCNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Presented response: held under backpressure, refilled on the handshake edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (q_pop_c) begin
            rsp_valid <= 1'b1;
            rsp_data  <= q_mem[q_rptr];
        end else if (rsp_take_c) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef CG_SRAM_RESPONDER_STATS_EN
    // Saturating activity counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_count    <= '0;
            o_wr_count    <= '0;
            o_stall_count <= '0;
        end else begin
            if (rd_grant_c && o_rd_count != '1) o_rd_count <= o_rd_count + 32'd1;
            if (wr_grant_c && bus.wen && o_wr_count != '1) o_wr_count <= o_wr_count + 32'd1;
            if (bus.raddr_valid && !rd_grant_c && o_stall_count != '1)
                o_stall_count <= o_stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cg_sram_responder.sv
// Self-checking bench for cg_sram_responder: directed vector table, multi-cycle
// corner sequences and randomized traffic against a transaction-level model.
module tb_cg_sram_responder;
    localparam int unsigned AW = 32, DW = 32, DEPTH = 1024, RL = 2, RD = 4, SL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cg_sram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef CG_SRAM_RESPONDER_STATS_EN
    logic [31:0] rd_count, wr_count, stall_count;
`endif

    cg_sram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(RL), .RESP_DEPTH(RD), .STARVE_LIMIT(SL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
`ifdef CG_SRAM_RESPONDER_STATS_EN
        ,
        .o_rd_count(rd_count),
        .o_wr_count(wr_count),
        .o_stall_count(stall_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model
    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        longint        t_acc;
    } rsp_t;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    rsp_t          m_q[$];
    longint        edge_n = 0;
    longint        last_h = 0;
    int            m_starve = 0;
    int            m_rd = 0, m_wr = 0, m_stall = 0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
    end

    // Every cycle: predict grants and response from the model, compare, then advance it
    initial begin
        bit            exp_rg, exp_wg, exp_rv, cred, rv, wv, wen_s, rr;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        longint        t_ok;
        rsp_t          e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_q.delete();
                m_starve = 0;
                m_rd = 0; m_wr = 0; m_stall = 0;
                check("reset_rdata_valid", bus.rdata_valid, 0);
                check("reset_raddr_ready", bus.raddr_ready, 0);
                check("reset_wdata_ready", bus.wdata_ready, 0);
                continue;
            end
            rv = bus.raddr_valid; ra = bus.raddr; wv = bus.wdata_valid;
            wen_s = bus.wen; wa = bus.waddr; wd = bus.wdata; rr = bus.rdata_ready;
            cred   = m_q.size() < int'(RD);
            exp_rg = rv && cred && (!wv || m_starve == int'(SL));
            exp_wg = wv && !exp_rg;
            exp_rv = 1'b0;
            if (m_q.size() > 0) begin
                t_ok = m_q[0].t_acc + RL;
                if (last_h > t_ok) t_ok = last_h;
                exp_rv = edge_n >= t_ok;
            end
            check("raddr_ready", bus.raddr_ready, exp_rg);
            check("wdata_ready", bus.wdata_ready, exp_wg);
            check("rdata_valid", bus.rdata_valid, exp_rv);
            if (exp_rv && bus.rdata_valid === 1'b1 && m_q[0].known)
                check("rdata", bus.rdata, m_q[0].data);
            if (rv && !exp_rg) m_stall++;
            @(posedge clk);
            edge_n++;
            if (!rst) begin
                if (exp_rv && rr) begin
                    void'(m_q.pop_front());
                    last_h = edge_n;
                end
                if (exp_rg) begin
                    e.data  = m_mem[ra[9:0]];
                    e.known = m_known[ra[9:0]];
                    e.t_acc = edge_n;
                    m_q.push_back(e);
                    m_rd++;
                end
                if (exp_rg || !rv) m_starve = 0;
                else if (exp_wg && cred && m_starve < int'(SL)) m_starve++;
                if (exp_wg && wen_s) begin
                    m_mem[wa[9:0]]   = wd;
                    m_known[wa[9:0]] = 1'b1;
                    m_wr++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic idle();
        bus.raddr_valid = 1'b0;
        bus.wdata_valid = 1'b0;
        bus.wen         = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w);
        bit got = 1'b0;
        @(negedge clk);
        bus.wdata_valid = 1'b1; bus.waddr = a; bus.wdata = d; bus.wen = w;
        for (int i = 0; i < 20 && !got; i++) begin
            #3;
            got = bus.wdata_ready;
            @(negedge clk);
        end
        bus.wdata_valid = 1'b0;
        check("wr_accept", got, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bit            got = 1'b0, seen = 1'b0;
        longint        t_acc = 0, lat = 0;
        logic [DW-1:0] d = '0;
        @(negedge clk);
        bus.raddr_valid = 1'b1; bus.raddr = a; bus.rdata_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #3;
            got = bus.raddr_ready;
            t_acc = edge_n + 1;
            @(negedge clk);
        end
        bus.raddr_valid = 1'b0;
        check("rd_accept", got, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            #3;
            if (bus.rdata_valid) begin
                seen = 1'b1; d = bus.rdata; lat = edge_n - t_acc;
            end else begin
                @(negedge clk);
            end
        end
        check("rd_seen", seen, 1);
        check("rd_data", d, exp);
        check("rd_latency", lat, RL);
    endtask

    typedef struct {
        bit            is_rd;
        bit            wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    localparam int NV = 12;
    logic [AW-1:0] bp_addr [6];
    logic [DW-1:0] tmp;

    initial begin
        vec_t tbl [NV];
        int   acc, nresp, rd_g, wr_g, waitc, maxw, stale;

        tbl = '{
            '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF},
            '{1'b1, 1'b0, 32'd5,          32'hDEADBEEF},
            '{1'b0, 1'b1, 32'd7,          32'h11111111},
            '{1'b0, 1'b0, 32'd7,          32'h22222222},
            '{1'b1, 1'b0, 32'd7,          32'h11111111},
            '{1'b1, 1'b0, 32'd1031,       32'h11111111},
            '{1'b1, 1'b0, 32'h8000_0005,  32'hDEADBEEF},
            '{1'b0, 1'b1, 32'd1023,       32'hA5A55A5A},
            '{1'b1, 1'b0, 32'd2047,       32'hA5A55A5A},
            '{1'b0, 1'b1, 32'd0,          32'h0BADF00D},
            '{1'b1, 1'b0, 32'd1024,       32'h0BADF00D},
            '{1'b1, 1'b0, 32'd5,          32'hDEADBEEF}
        };
        bp_addr = '{32'd5, 32'd7, 32'd0, 32'd1023, 32'd5, 32'd7};

        rst = 1'b1;
        bus.raddr_valid = 1'b1; bus.wdata_valid = 1'b1; bus.wen = 1'b1;
        bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.rdata_ready = 1'b0;
        #13;
        check("rst_raddr_ready", bus.raddr_ready, 0);
        check("rst_wdata_ready", bus.wdata_ready, 0);
        check("rst_rdata_valid", bus.rdata_valid, 0);
        check("rst_rdata", bus.rdata, 0);
        idle();
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_rd) do_read(tbl[i].addr, tbl[i].data);
            else              do_write(tbl[i].addr, tbl[i].data, tbl[i].wen);
        end

        // Backpressure: credit caps outstanding reads at RESP_DEPTH
        acc = 0;
        @(negedge clk);
        bus.rdata_ready = 1'b0; bus.raddr_valid = 1'b1; bus.raddr = bp_addr[0];
        for (int c = 0; c < 8; c++) begin
            #3;
            if (bus.raddr_ready) acc++;
            @(negedge clk);
            if (acc < 6) bus.raddr = bp_addr[acc]; else bus.raddr_valid = 1'b0;
        end
        check("bp_accepts", acc, RD);
        #3;
        check("bp_ready_low", bus.raddr_ready, 0);
        @(negedge clk);
        bus.rdata_ready = 1'b1;
        nresp = 0;
        for (int c = 0; c < 4; c++) begin
            #3;
            if (bus.rdata_valid) nresp++;
            if (bus.raddr_valid && bus.raddr_ready) acc++;
            @(negedge clk);
            if (acc < 6) bus.raddr = bp_addr[acc]; else bus.raddr_valid = 1'b0;
        end
        check("bp_rate", nresp, 4);
        for (int c = 0; c < 20 && acc < 6; c++) begin
            #3;
            if (bus.raddr_valid && bus.raddr_ready) acc++;
            @(negedge clk);
            if (acc < 6) bus.raddr = bp_addr[acc]; else bus.raddr_valid = 1'b0;
        end
        bus.raddr_valid = 1'b0;
        check("bp_total_accepts", acc, 6);
        repeat (10) @(negedge clk);
        #3;
        check("bp_drained", bus.rdata_valid, 0);

        // Starvation: both channels valid continuously
        @(negedge clk);
        bus.raddr_valid = 1'b1; bus.raddr = 32'd5;
        bus.wdata_valid = 1'b1; bus.wen = 1'b0; bus.waddr = 32'd9; bus.wdata = 32'h0;
        rd_g = 0; wr_g = 0; waitc = 0; maxw = 0;
        for (int c = 0; c < 25; c++) begin
            #3;
            waitc++;
            if (bus.raddr_ready) begin
                rd_g++;
                if (waitc > maxw) maxw = waitc;
                waitc = 0;
            end
            if (bus.wdata_ready) wr_g++;
            @(negedge clk);
        end
        idle();
        check("starve_reads", rd_g, 5);
        check("starve_writes", wr_g, 20);
        check("starve_max_wait", maxw, SL + 1);
        repeat (6) @(negedge clk);

        // Asynchronous reset with three reads in flight
        acc = 0;
        bus.rdata_ready = 1'b0; bus.raddr_valid = 1'b1; bus.raddr = bp_addr[0];
        for (int c = 0; c < 10 && acc < 3; c++) begin
            #3;
            if (bus.raddr_ready) acc++;
            @(negedge clk);
            if (acc < 3) bus.raddr = bp_addr[acc]; else bus.raddr_valid = 1'b0;
        end
        check("rst_seq_accepts", acc, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_drop_valid", bus.rdata_valid, 0);
        check("rst_drop_rdata", bus.rdata, 0);
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        bus.rdata_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            if (bus.rdata_valid) stale++;
        end
        check("rst_no_stale", stale, 0);
        do_read(32'd5, 32'hDEADBEEF);
        do_read(32'd1023, 32'hA5A55A5A);

        // Randomized traffic over a small aliased address window
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.raddr_valid = ($urandom % 2) == 0;
            tmp = $urandom;
            bus.raddr = (tmp & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
            bus.wdata_valid = ($urandom % 3) == 0;
            tmp = $urandom;
            bus.waddr = (tmp & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
            bus.wdata = $urandom;
            bus.wen = ($urandom % 4) != 0;
            bus.rdata_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        idle();
        bus.rdata_ready = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        check("final_idle_valid", bus.rdata_valid, 0);

`ifdef CG_SRAM_RESPONDER_STATS_EN
        check("stats_rd", rd_count, 32'(m_rd));
        check("stats_wr", wr_count, 32'(m_wr));
        check("stats_stall", stall_count, 32'(m_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
